// File: rtl/multicycle_control_fsm.sv
// Sequencing controller for the multi-cycle RV32I datapath: walks each instruction
// through 2-5 states, driving mux selects, write enables and ALU op, stalling on MemReady.
module multicycle_control_fsm (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        Zero,
  input  logic        MemReady,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        AdrSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [2:0]  ALUctrl,
  output logic [2:0]  ImmSrc,
  output logic        InstrDone,
  output logic        IllegalInstr
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIType  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;

  localparam logic [2:0] AluAdd  = 3'b000;
  localparam logic [2:0] AluSub  = 3'b001;
  localparam logic [2:0] AluAnd  = 3'b010;
  localparam logic [2:0] AluOr   = 3'b011;
  localparam logic [2:0] AluSll  = 3'b100;
  localparam logic [2:0] AluSlt  = 3'b101;
  localparam logic [2:0] AluPass = 3'b110;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
    S_EXECI, S_ALUWB, S_BRANCH, S_JALRADR, S_JAL, S_LUI
  } state_e;

  state_e state_q, state_d;

  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic [2:0] execCtrl;
  logic       unusedInstrBits;

  assign op       = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7b5 = instr[30];
  assign unusedInstrBits = ^{instr[31], instr[29:15], instr[11:7]};

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    unique case (op)
      OpLoad, OpIType, OpJalr: ImmSrc = 3'b000;
      OpStore:                 ImmSrc = 3'b001;
      OpBranch:                ImmSrc = 3'b010;
      OpJal:                   ImmSrc = 3'b011;
      OpLui:                   ImmSrc = 3'b100;
      default:                 ImmSrc = 3'b000;
    endcase
  end

  // Subtract only exists for register-register funct3=000; addi ignores bit 30.
  always_comb begin
    unique case (funct3)
      3'b000:  execCtrl = (op == OpRType && funct7b5) ? AluSub : AluAdd;
      3'b010:  execCtrl = AluSlt;
      3'b110:  execCtrl = AluOr;
      3'b111:  execCtrl = AluAnd;
      3'b001:  execCtrl = AluSll;
      default: execCtrl = AluAdd;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    PCWrite      = 1'b0;
    IRWrite      = 1'b0;
    RegWrite     = 1'b0;
    MemWrite     = 1'b0;
    AdrSrc       = 1'b0;
    ALUSrcA      = 2'b00;
    ALUSrcB      = 2'b00;
    ResultSrc    = 2'b00;
    ALUctrl      = AluAdd;
    InstrDone    = 1'b0;
    IllegalInstr = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        PCWrite   = MemReady;
        IRWrite   = MemReady;
        if (MemReady) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        unique case (op)
          OpLoad, OpStore: state_d = S_MEMADR;
          OpRType:         state_d = S_EXECR;
          OpIType:         state_d = S_EXECI;
          OpBranch:        state_d = S_BRANCH;
          OpJal:           state_d = S_JAL;
          OpJalr:          state_d = S_JALRADR;
          OpLui:           state_d = S_LUI;
          default: begin
            state_d      = S_FETCH;
            IllegalInstr = 1'b1;
            InstrDone    = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (MemReady) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc    = 1'b1;
        MemWrite  = 1'b1;
        InstrDone = MemReady;
        if (MemReady) state_d = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        ALUctrl = execCtrl;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUctrl = execCtrl;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA   = 2'b10;
        ALUctrl   = AluSub;
        InstrDone = 1'b1;
        PCWrite   = (funct3 == 3'b000 && Zero) || (funct3 == 3'b001 && !Zero);
        state_d   = S_FETCH;
      end
      S_JALRADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = S_JAL;
      end
      // Target already sits in ALUOut; the ALU meanwhile forms the link address.
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
        state_d = S_ALUWB;
      end
      S_LUI: begin
        ALUSrcB = 2'b01;
        ALUctrl = AluPass;
        state_d = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset suppresses every write in the cycle it is seen, including a pending store.
    if (rst) begin
      state_d      = S_FETCH;
      PCWrite      = 1'b0;
      IRWrite      = 1'b0;
      RegWrite     = 1'b0;
      MemWrite     = 1'b0;
      InstrDone    = 1'b0;
      IllegalInstr = 1'b0;
      AdrSrc       = 1'b0;
      ALUSrcA      = 2'b00;
      ALUSrcB      = 2'b10;
      ResultSrc    = 2'b10;
      ALUctrl      = AluAdd;
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench: each instruction's per-cycle outputs are predicted from its class,
// base CPI and the chosen memory stall counts, then compared cycle by cycle.
module tb_multicycle_control_fsm;

  logic        clk = 1'b0;
  logic        rst, Zero, MemReady;
  logic [31:0] instr;
  logic        PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, InstrDone, IllegalInstr;
  logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc;
  logic [2:0]  ALUctrl, ImmSrc;

  int checks = 0;
  int errors = 0;

  typedef enum int {C_LOAD, C_STORE, C_RTYPE, C_ITYPE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_ILL} cls_e;

  multicycle_control_fsm dut (
    .clk(clk), .rst(rst), .instr(instr), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ALUctrl(ALUctrl), .ImmSrc(ImmSrc), .InstrDone(InstrDone), .IllegalInstr(IllegalInstr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic applyStimulus(input logic r, input logic mr, input logic z, input logic [31:0] ins);
    @(posedge clk);
    #1;
    rst = r; MemReady = mr; Zero = z; instr = ins;
    @(negedge clk);
  endtask

  function automatic cls_e classOf(input logic [6:0] op);
    case (op)
      7'h03: return C_LOAD;
      7'h23: return C_STORE;
      7'h33: return C_RTYPE;
      7'h13: return C_ITYPE;
      7'h63: return C_BRANCH;
      7'h6F: return C_JAL;
      7'h67: return C_JALR;
      7'h37: return C_LUI;
      default: return C_ILL;
    endcase
  endfunction

  function automatic int baseCpi(input cls_e c);
    case (c)
      C_BRANCH:       return 3;
      C_LOAD, C_JALR: return 5;
      C_ILL:          return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic logic [2:0] immFormat(input logic [6:0] op);
    case (classOf(op))
      C_STORE:  return 3'd1;
      C_BRANCH: return 3'd2;
      C_JAL:    return 3'd3;
      C_LUI:    return 3'd4;
      default:  return 3'd0;
    endcase
  endfunction

  // Arithmetic operation named by the instruction, mapped to the ALU code.
  function automatic logic [2:0] aluFor(input logic [31:0] ins);
    logic [2:0] f3;
    f3 = ins[14:12];
    if (f3 == 3'b010) return 3'd5;
    if (f3 == 3'b110) return 3'd3;
    if (f3 == 3'b111) return 3'd2;
    if (f3 == 3'b001) return 3'd4;
    if (f3 == 3'b000 && ins[6:0] == 7'h33 && ins[30]) return 3'd1;
    return 3'd0;
  endfunction

  function automatic logic writesReg(input cls_e c);
    return c == C_LOAD || c == C_RTYPE || c == C_ITYPE || c == C_JAL || c == C_JALR || c == C_LUI;
  endfunction

  // zeroSel: 0/1 forces Zero, anything else randomizes it each cycle.
  task automatic runInstr(input logic [31:0] ins, input int fWait, input int mWait, input int zeroSel);
    cls_e cls;
    logic isMem, mr, z, memPhase, taken, expPc;
    logic [31:0] drive;
    int m, total, k;
    cls   = classOf(ins[6:0]);
    isMem = (cls == C_LOAD || cls == C_STORE);
    m     = isMem ? mWait : 0;
    total = fWait + baseCpi(cls) + m;
    for (int c = 0; c < total; c++) begin
      k        = c - fWait;
      memPhase = isMem && k >= 3 && k <= 3 + m;
      if (c < fWait || (memPhase && k < 3 + m)) mr = 1'b0;
      else if (c == fWait || memPhase)         mr = 1'b1;
      else                                      mr = 1'($urandom_range(1));
      z     = (zeroSel == 0 || zeroSel == 1) ? 1'(zeroSel) : 1'($urandom_range(1));
      drive = (c <= fWait) ? $urandom : ins;
      applyStimulus(1'b0, mr, z, drive);

      taken = (ins[14:12] == 3'b000 && z) || (ins[14:12] == 3'b001 && !z);
      expPc = (c == fWait) || ((cls == C_JAL || cls == C_JALR) && c == total - 2)
              || (cls == C_BRANCH && c == total - 1 && taken);
      checkOutput($sformatf("PCWrite %08h c%0d", ins, c), PCWrite, expPc);
      checkOutput($sformatf("IRWrite %08h c%0d", ins, c), IRWrite, c == fWait);
      checkOutput($sformatf("InstrDone %08h c%0d", ins, c), InstrDone, c == total - 1);
      checkOutput($sformatf("Illegal %08h c%0d", ins, c), IllegalInstr, cls == C_ILL && c == total - 1);
      checkOutput($sformatf("RegWrite %08h c%0d", ins, c), RegWrite, writesReg(cls) && c == total - 1);
      checkOutput($sformatf("MemWrite %08h c%0d", ins, c), MemWrite, cls == C_STORE && k >= 3);
      checkOutput($sformatf("ImmSrc %08h c%0d", ins, c), ImmSrc, immFormat(drive[6:0]));

      if (c <= fWait) begin
        checkOutput("FetchSel", {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUctrl}, {1'b0, 2'd0, 2'd2, 2'd2, 3'd0});
      end else if (k == 1) begin
        checkOutput("DecodeSel", {ALUSrcA, ALUSrcB, ALUctrl}, {2'd1, 2'd1, 3'd0});
      end else if (k == 2) begin
        case (cls)
          C_RTYPE:  checkOutput("ExecR", {ALUSrcA, ALUSrcB, ALUctrl}, {2'd2, 2'd0, aluFor(ins)});
          C_ITYPE:  checkOutput("ExecI", {ALUSrcA, ALUSrcB, ALUctrl}, {2'd2, 2'd1, aluFor(ins)});
          C_BRANCH: checkOutput("Branch", {ALUSrcA, ALUSrcB, ALUctrl, ResultSrc}, {2'd2, 2'd0, 3'd1, 2'd0});
          C_LUI:    checkOutput("Lui", {ALUSrcB, ALUctrl}, {2'd1, 3'd6});
          C_JAL:    checkOutput("JalLink", {ALUSrcA, ALUSrcB, ALUctrl, ResultSrc}, {2'd1, 2'd2, 3'd0, 2'd0});
          C_ILL:    ;
          default:  checkOutput("AddrCalc", {ALUSrcA, ALUSrcB, ALUctrl}, {2'd2, 2'd1, 3'd0});
        endcase
      end else if (cls == C_JALR && k == 3) begin
        checkOutput("JalrLink", {ALUSrcA, ALUSrcB, ALUctrl}, {2'd1, 2'd2, 3'd0});
      end
      if (memPhase) checkOutput("MemAccess", {AdrSrc, ResultSrc}, {1'b1, 2'd0});
      if (writesReg(cls) && c == total - 1)
        checkOutput("WbResult", ResultSrc, (cls == C_LOAD) ? 2'd1 : 2'd0);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " enables"}, {PCWrite, IRWrite, RegWrite, MemWrite, InstrDone, IllegalInstr}, 6'd0);
    checkOutput({tag, " selects"}, {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUctrl}, {1'b0, 2'd0, 2'd2, 2'd2, 3'd0});
  endtask

  logic [6:0] legalOps [8] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h37};

  initial begin
    logic [6:0]  op;
    logic [31:0] sw;
    rst = 1'b1; MemReady = 1'b1; Zero = 1'b0; instr = 32'h0;

    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b1, 1'($urandom_range(1)), $urandom);
      checkResetOutputs("Reset");
    end

    runInstr(32'h00500093, 0, 0, 2);
    runInstr(32'h40208133, 0, 0, 2);
    runInstr(32'h00208133, 1, 0, 2);
    runInstr(32'h0000A103, 0, 3, 2);
    runInstr(32'h0020A023, 0, 2, 2);
    runInstr(32'h00208463, 0, 0, 1);
    runInstr(32'h00208463, 0, 0, 0);
    runInstr(32'h00209463, 0, 0, 1);
    runInstr(32'h00209463, 0, 0, 0);
    runInstr(32'h00A0A463, 0, 0, 1);
    runInstr(32'h000080E7, 0, 0, 2);
    runInstr(32'h0000007F, 0, 0, 2);
    runInstr(32'h008000EF, 2, 0, 2);
    runInstr(32'h000012B7, 0, 0, 2);

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(8) == 0) begin
        do op = 7'($urandom); while (classOf(op) != C_ILL);
      end else begin
        op = legalOps[$urandom_range(7)];
      end
      runInstr(($urandom & 32'hFFFF_FF80) | {25'd0, op}, $urandom_range(3), $urandom_range(3), 2);
    end

    sw = 32'h0020A023;
    applyStimulus(1'b0, 1'b1, 1'b0, sw);
    checkOutput("StoreAbort fetch", IRWrite, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, sw);
    applyStimulus(1'b0, 1'b0, 1'b0, sw);
    applyStimulus(1'b0, 1'b0, 1'b0, sw);
    checkOutput("StoreAbort pending", MemWrite, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, sw);
    checkResetOutputs("StoreAbort rst");
    applyStimulus(1'b0, 1'b1, 1'b0, sw);
    checkOutput("StoreAbort refetch", {IRWrite, PCWrite, MemWrite}, 3'b110);
    applyStimulus(1'b1, 1'b0, 1'b0, sw);
    checkResetOutputs("Reset decode");
    runInstr(32'h00500093, 0, 0, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Sequencing controller for the multi-cycle RV32I datapath variant: one shared ALU, one shared instruction/data memory port, and architectural registers PC, OldPC, IR, Data, A, B and ALUOut. Every instruction is broken into 2–5 states. The block drives the mux selects, write enables and ALU operation each cycle, and stalls on a memory-ready handshake. It replaces the single-cycle decoder in the multi-cycle top level and keeps the same ALUctrl and ImmSrc encodings.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, synchronous and active-high.
- instr  in  32  IR contents; fields used: op[6:0], funct3[14:12], funct7[5] (bit 30).
- Zero  in  1  ALU zero flag for the current cycle.
- MemReady  in  1  memory port completes the current read or write this cycle.
- PCWrite  out  1  PC load enable.
- IRWrite  out  1  IR and OldPC load enable.
- RegWrite  out  1  register-file write enable.
- MemWrite  out  1  memory write strobe.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = Result.
- ALUSrcA  out  2  ALU A operand: 00 = PC, 01 = OldPC, 10 = A.
- ALUSrcB  out  2  ALU B operand: 00 = B, 01 = ImmExt, 10 = constant 4.
- ResultSrc  out  2  result mux: 00 = ALUOut, 01 = Data, 10 = ALU result.
- ALUctrl  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 100 sll, 101 slt, 110 pass SrcB.
- ImmSrc  out  3  immediate format: 000 I, 001 S, 010 B, 011 J, 100 U. Combinational from op in every state; 000 for unknown op.
- InstrDone  out  1  1-cycle pulse in the final state of each instruction.
- IllegalInstr  out  1  1-cycle pulse in DECODE when op is unsupported.

## Operation
- States and outputs. Unlisted enables are 0; unlisted selects are don't-care (RTL drives 0).
  - FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUctrl=add, ResultSrc=10. PCWrite = IRWrite = MemReady. If MemReady, go to DECODE; else stay.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUctrl=add, so ALUOut = OldPC + imm. Next state by op:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 1100111 → JALRADR
    - 0110111 → LUI
    - other → FETCH, with IllegalInstr=1 and InstrDone=1.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, add. Next: MEMREAD if op[5]=0, else MEMWRITE.
  - MEMREAD: AdrSrc=1, ResultSrc=00. Go to MEMWB on MemReady; else stay.
  - MEMWB: ResultSrc=01, RegWrite=1, InstrDone=1. Next: FETCH.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1, held every cycle until MemReady. InstrDone=MemReady. Go to FETCH on MemReady.
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALUctrl decoded. Next: ALUWB.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ALUctrl decoded. Next: ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1, InstrDone=1. Next: FETCH.
  - BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, InstrDone=1. PCWrite = (funct3=000 & Zero) | (funct3=001 & !Zero); 0 for any other funct3. Next: FETCH.
  - JALRADR: ALUSrcA=10, ALUSrcB=01, add. Next: JAL.
  - JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1. PC ← target held in ALUOut; ALUOut ← OldPC+4. Next: ALUWB.
  - LUI: ALUSrcB=01, ALUctrl=110. Next: ALUWB.
- ALUctrl decode in EXECR/EXECI, by funct3:
  - 000: sub only when op=0110011 and funct7[5]=1; otherwise add.
  - 010: slt. 110: or. 111: and. 001: sll.
  - Any other funct3: add.
- Bit 0 of the JALR target is not cleared here; that belongs to the datapath.

## Timing
- Moore outputs from the state register, except the MemReady- and Zero-qualified terms.
- Cycles per instruction with MemReady held high:
  - branch: 3
  - R-type, I-type ALU, lui, jal, sw: 4
  - lw, jalr: 5
  - illegal: 2
- Each cycle MemReady is low in FETCH, MEMREAD or MEMWRITE adds one cycle. There is no timeout.
- Reset:
  - rst high forces state FETCH at the next edge.
  - While rst is high, PCWrite, IRWrite, RegWrite, MemWrite, InstrDone and IllegalInstr are 0, and the selects take their FETCH values.
  - Reset mid-store drops MemWrite in the same cycle rst is seen.
- instr is sampled only while IR is stable, i.e. outside FETCH. Changes to instr during FETCH have no effect on state.
- Simultaneous rst and MemReady: rst wins; no PC or IR write occurs.

## Test plan
- Reset, then MemReady=1, instr=0x00500093 (addi x1,x0,5): states FETCH→DECODE→EXECI→ALUWB. RegWrite=1 only in cycle 4, ALUctrl=000, InstrDone pulses once.
- instr=0x40208133 (sub): EXECR gives ALUctrl=001. Same bits with funct7[5]=0 (add) give 000.
- lw 0x0000A103 with MemReady low for 3 cycles in MEMREAD: MEMWB is reached 3 cycles late, 8 cycles total. RegWrite=1 with ResultSrc=01.
- sw 0x0020A023, MemReady low 2 cycles: MemWrite=1 for 3 consecutive cycles. InstrDone on the third; next state FETCH.
- beq 0x00208463: with Zero=1, PCWrite=1 in BRANCH; with Zero=0, PCWrite=0. bne (funct3=001) gives the inverse.
- jalr 0x000080E7: sequence JALRADR→JAL→ALUWB with PCWrite=1 in JAL. Next, op=0x7F gives IllegalInstr=1 in DECODE and a return to FETCH with no writes. Finally, rst during MEMWRITE drops MemWrite immediately.
